// File: rtl/smpc_pad_poll.sv
// SMPC direct-mode peripheral scanner: walks TH/TR on both control ports and writes INTBACK pad bytes to OREG.
// Build macro SMPC_PAD_PORT2_EN enables scanning of port 2; without it port 2 always reports F0.
module smpc_pad_poll #(
    parameter int SETTLE  = 20,
    parameter int OUT_LEN = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CE,
    input  logic       START,
    input  logic       BREAK,
    input  logic [1:0] PORT_EN,
    output logic       BUSY,
    output logic       DONE,
    output logic       ABORTED,
    output logic       OUT_WE,
    output logic [4:0] OUT_ADDR,
    output logic [7:0] OUT_DATA,
    input  logic [6:0] P1I,
    output logic [6:0] P1O,
    output logic [6:0] P1OE,
    input  logic [6:0] P2I,
    output logic [6:0] P2O,
    output logic [6:0] P2OE,
    output logic [2:0] DBG_STATE
);

`ifdef SMPC_PAD_PORT2_EN
    localparam logic PORT2_SCAN = 1'b1;
`else
    localparam logic PORT2_SCAN = 1'b0;
`endif
    localparam logic [7:0] SETTLE_LD = 8'(SETTLE - 1);
    localparam logic [5:0] LEN       = 6'(OUT_LEN);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEL    = 3'd1,
        S_WAIT   = 3'd2,
        S_SAMPLE = 3'd3,
        S_EMIT   = 3'd4,
        S_PAD    = 3'd5,
        S_FIN    = 3'd6
    } state_t;

    state_t      state;
    logic [7:0]  settle_cnt;
    logic [1:0]  phase;
    logic [1:0]  byte_idx;
    logic        port_q;
    logic [1:0]  scan_en;
    logic [5:0]  addr;
    logic [15:0] nibs;
    logic [1:0]  p1_sel;
    logic [1:0]  p2_sel;

    logic [3:0]  pin_nib;
    logic        pad_id_ok;
    logic        last_byte;
    logic [7:0]  emit_byte;
    logic [5:0]  addr_nx;
    logic [1:0]  sel_code;

    // nibs holds {n0,n1,n2,n3}; n3[2:0]==100 identifies a standard digital pad
    always_comb begin
        pin_nib   = port_q ? P2I[3:0] : P1I[3:0];
        pad_id_ok = scan_en[port_q] && (nibs[2:0] == 3'b100);
        addr_nx   = addr + 6'd1;
        sel_code  = {~phase[0], ~phase[1]};
        emit_byte = 8'hF0;
        last_byte = 1'b1;
        if (pad_id_ok) begin
            last_byte = (byte_idx == 2'd3);
            case (byte_idx)
                2'd0:    emit_byte = 8'hF1;
                2'd1:    emit_byte = 8'h02;
                2'd2:    emit_byte = nibs[15:8];
                default: emit_byte = nibs[7:0];
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            ABORTED    <= 1'b0;
            OUT_WE     <= 1'b0;
            OUT_ADDR   <= 5'd0;
            OUT_DATA   <= 8'd0;
            settle_cnt <= 8'd0;
            phase      <= 2'd0;
            byte_idx   <= 2'd0;
            port_q     <= 1'b0;
            scan_en    <= 2'b00;
            addr       <= 6'd0;
            nibs       <= 16'd0;
            p1_sel     <= 2'b11;
            p2_sel     <= 2'b11;
        end else if (CE) begin
            DONE    <= 1'b0;
            ABORTED <= 1'b0;
            OUT_WE  <= 1'b0;
            if (BREAK && state != S_IDLE) begin
                state   <= S_IDLE;
                BUSY    <= 1'b0;
                ABORTED <= 1'b1;
                p1_sel  <= 2'b11;
                p2_sel  <= 2'b11;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (START) begin
                            BUSY     <= 1'b1;
                            port_q   <= 1'b0;
                            addr     <= 6'd0;
                            phase    <= 2'd0;
                            byte_idx <= 2'd0;
                            scan_en  <= {PORT2_SCAN & PORT_EN[1], PORT_EN[0]};
                            state    <= PORT_EN[0] ? S_SEL : S_EMIT;
                        end
                    end
                    S_SEL: begin
                        if (port_q) p2_sel <= sel_code;
                        else        p1_sel <= sel_code;
                        settle_cnt <= SETTLE_LD;
                        state      <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (settle_cnt == 8'd0) state <= S_SAMPLE;
                        else                    settle_cnt <= settle_cnt - 8'd1;
                    end
                    S_SAMPLE: begin
                        nibs <= {nibs[11:0], pin_nib};
                        if (phase == 2'd3) begin
                            if (port_q) p2_sel <= 2'b11;
                            else        p1_sel <= 2'b11;
                            byte_idx <= 2'd0;
                            state    <= S_EMIT;
                        end else begin
                            phase <= phase + 2'd1;
                            state <= S_SEL;
                        end
                    end
                    S_EMIT: begin
                        // bytes past the end of the OREG window are consumed but not written
                        OUT_WE   <= (addr < LEN);
                        OUT_ADDR <= addr[4:0];
                        OUT_DATA <= emit_byte;
                        addr     <= addr_nx;
                        if (last_byte) begin
                            byte_idx <= 2'd0;
                            phase    <= 2'd0;
                            if (!port_q) begin
                                port_q <= 1'b1;
                                state  <= scan_en[1] ? S_SEL : S_EMIT;
                            end else begin
                                state <= (addr_nx >= LEN) ? S_FIN : S_PAD;
                            end
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                    S_PAD: begin
                        OUT_WE   <= 1'b1;
                        OUT_ADDR <= addr[4:0];
                        OUT_DATA <= 8'h00;
                        addr     <= addr_nx;
                        if (addr_nx >= LEN) state <= S_FIN;
                    end
                    S_FIN: begin
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign P1O       = {p1_sel, 5'b00000};
    assign P1OE      = 7'h60;
    assign P2OE      = 7'h60;
    assign DBG_STATE = state;

`ifdef SMPC_PAD_PORT2_EN
    assign P2O = {p2_sel, 5'b00000};
    wire unused_pins = &{1'b0, P1I[6:4], P2I[6:4]};
`else
    assign P2O = 7'h60;
    wire unused_pins = &{1'b0, P1I[6:4], P2I[6:4], p2_sel};
`endif

endmodule
